// File: rtl/conv_cluster.sv
// Row-serial 5x5 convolution: one kernel row per beat, three-stage pipeline.
// Define CONV_CLUSTER_SAT_EN to clamp the result to 0..255 instead of wrapping.
module conv_cluster #(
  parameter int KERNEL_SIZE = 5,
  parameter int SHIFT       = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_pixel_0,
  input  logic [7:0]                 i_pixel_1,
  input  logic [7:0]                 i_pixel_2,
  input  logic [7:0]                 i_pixel_3,
  input  logic [7:0]                 i_pixel_4,
  input  logic                       i_valid,
  input  logic                       i_clear,
  input  logic                       i_kload,
  input  logic [2:0]                 i_krow,
  input  logic [8*KERNEL_SIZE-1:0]   i_kcoef,
  output logic [7:0]                 o_res,
  output logic                       o_valid,
  output logic                       o_busy
);

  localparam int K = KERNEL_SIZE;
  localparam logic [2:0] RC_LAST = 3'(K - 1);

  logic        [7:0]  pix    [K];
  logic signed [7:0]  coef   [K][K];
  logic signed [16:0] prod_d [K];
  logic signed [16:0] prod   [K];
  logic        [2:0]  rc;
  logic               beat;
  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic signed [19:0] row_sum;
  logic signed [21:0] acc;
  logic signed [21:0] acc_d;
  logic               s2_valid;
  logic               s2_last;
  logic        [7:0]  res_d;

  assign pix[0] = i_pixel_0;
  assign pix[1] = i_pixel_1;
  assign pix[2] = i_pixel_2;
  assign pix[3] = i_pixel_3;
  assign pix[4] = i_pixel_4;

  // clear wins over a coincident beat
  assign beat   = i_valid & ~i_clear;
  assign o_busy = (rc != 3'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < K; r++)
        for (int t = 0; t < K; t++)
          coef[r][t] <= '0;
    end else if (i_kload && (i_krow < 3'(K))) begin
      for (int t = 0; t < K; t++)
        coef[i_krow][t] <= i_kcoef[8*t +: 8];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      rc <= '0;
    else if (i_clear)
      rc <= '0;
    else if (i_valid)
      rc <= (rc == RC_LAST) ? 3'd0 : rc + 3'd1;
  end

  always_comb begin
    for (int t = 0; t < K; t++)
      prod_d[t] = signed'({9'b0, pix[t]}) * 17'(coef[rc][t]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int t = 0; t < K; t++)
        prod[t] <= '0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_first <= (rc == 3'd0);
        s1_last  <= (rc == RC_LAST);
        for (int t = 0; t < K; t++)
          prod[t] <= prod_d[t];
      end
    end
  end

  always_comb begin
    row_sum = '0;
    for (int t = 0; t < K; t++)
      row_sum = row_sum + 20'(prod[t]);
    acc_d = (s1_first ? 22'sd0 : acc) + 22'(row_sum);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      acc      <= '0;
    end else begin
      s2_valid <= s1_valid & ~i_clear;
      s2_last  <= s1_last;
      if (s1_valid)
        acc <= acc_d;
    end
  end

`ifdef CONV_CLUSTER_SAT_EN
  logic signed [21:0] shifted;
  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted < 22'sd0)
      res_d = 8'h00;
    else if (shifted > 22'sd255)
      res_d = 8'hFF;
    else
      res_d = shifted[7:0];
  end
`else
  always_comb begin
    res_d = 8'(acc >>> SHIFT);
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_res   <= '0;
    end else begin
      o_valid <= s2_valid & s2_last;
      if (s2_valid & s2_last)
        o_res <= res_d;
    end
  end

endmodule

// File: doc/conv_cluster.md
# conv_cluster

Row-serial 5×5 convolution engine sitting directly downstream of `cluster_feeder`. Each valid beat consumes the feeder's five-pixel window `o_pixel_0..4` as one kernel row and multiplies it by the matching stored coefficient row. It accumulates five consecutive row beats into one output pixel. The result is then shifted, optionally saturated, and emitted as one 8-bit output pixel with a single-cycle valid strobe.

## Interface
- `KERNEL_SIZE`, 5, taps per row and rows per window (fixed at 5).
- `SHIFT`, 0, arithmetic right shift applied to the final sum (0..15).
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_pixel_0`..`i_pixel_4`  in  8 each  unsigned window pixels from `cluster_feeder`.
- `i_valid`  in  1  the pixels form a row beat this cycle.
- `i_clear`  in  1  synchronous abort of the current partial window.
- `i_kload`  in  1  write one coefficient row this cycle.
- `i_krow`  in  3  coefficient row index, 0..4.
- `i_kcoef`  in  40  five signed 8-bit coefficients; tap t is at bits [8t+7:8t].
- `o_res`  out  8  output pixel.
- `o_valid`  out  1  `o_res` is valid this cycle (one-cycle pulse).
- `o_busy`  out  1  a partial window is in progress (row counter ≠ 0).

## Operation
- **Coefficient store:** 5×5 signed 8-bit registers.
  - On `i_kload`, row `i_krow` is overwritten.
  - `i_krow` > 4 is ignored.
  - A write affects beats sampled from the next edge on. A beat in the same cycle uses the old row.
- **Row counter `rc`** (0..4), reset to 0.
  - Each accepted beat uses coefficient row `rc`, then increments `rc`.
  - `rc` wraps 4→0. Beat `rc`=0 is tagged *first*; beat `rc`=4 is tagged *last*.
  - Gaps between beats (`i_valid`=0) are allowed and hold all state.
- **Stage 1:** five products, pixel zero-extended to 9 bits × coefficient, giving signed 17-bit results. Registered together with the valid, first and last tags.
- **Stage 2:** row sum (signed 20 bits) is added to the accumulator (signed 22 bits). If the beat is tagged first, the accumulator is treated as 0. The result is registered into the accumulator, along with valid and last tags.
- **Stage 3:** when the stage-2 tag is valid and last:
  - the value is the accumulator arithmetic-shifted right by `SHIFT`;
  - `o_res` is that value, post-processed per Configuration;
  - `o_valid` = 1.
  - Otherwise `o_valid` = 0 and `o_res` holds its previous value.
- **`i_clear`:**
  - sets `rc` to 0 and kills the stage-1 and stage-2 valid tags, so no result is emitted for the aborted window;
  - coefficients are untouched;
  - `i_clear` together with `i_valid` in the same cycle: clear wins and the beat is dropped.
- **Reset:** all coefficients 0, `rc`=0, all pipeline tags 0, accumulator 0. `o_res`=0, `o_valid`=0, `o_busy`=0.
- Reset asserted mid-window discards the partial sum; the first beat after release is row 0.

## Timing
- The 5th beat of a window is sampled at edge N. The result is registered at edge N+2, so `o_valid` is high for exactly the cycle following N+2.
- Full throughput: back-to-back beats yield one result every 5 cycles. There is no stall or backpressure.
- `o_busy` is registered; it reflects `rc` after the edge.
- `i_kload` and `i_valid` in the same cycle are both honoured, independently.

## Configuration
- `CONV_CLUSTER_SAT_EN` defined: the shifted value is clamped to 0..255. Negative values give 0; values > 255 give 255.
- Undefined: `o_res` = bits [7:0] of the shifted value (two's-complement wrap). No clamp logic is present.

## Test plan
- **Reset:** assert `i_rst_n`=0 mid-window with `rc`=3 → `o_res`=0x00, `o_valid`=0, `o_busy`=0. After release, 5 beats give one result; no stale partial sum leaks in.
- **Uniform sum:** all coefficients 1, five back-to-back beats of pixels 10, `SHIFT`=0 → `o_res`=0xFA (250). `o_valid` is a single cycle, two edges after the 5th beat.
- **Overflow:** all coefficients 2, pixels 10 (sum 500) → `o_res`=0xFF with `CONV_CLUSTER_SAT_EN`, 0xF4 without.
- **Negative sum:** all coefficients −1 (0xFF), pixels 1 (sum −25) → `o_res`=0x00 with `CONV_CLUSTER_SAT_EN`, 0xE7 without.
- **Abort and gaps:** coefficients 1; 3 beats; `i_clear` asserted together with a 4th beat; then 5 beats of pixels 4 with idle gaps between them → exactly one `o_valid`, `o_res`=0x64 (100).
- **Per-row kernel:** row r coefficients = r+1, pixels 1, two back-to-back windows → `o_res`=0x4B (75) twice, with `o_valid` pulses 5 cycles apart. Rewrite row 0 to 0 on the same cycle as the second window's row-0 beat → second result is still 75; a third window gives 70 (0x46).
